codec_stream_arbiter: RTL and testbench

CODEC_STREAM_ARBITER -- requirements
Module: codec_stream_arbiter

---
 rtl/codec_stream_arbiter.sv | 153 +++++++++++++++
 tb/tb_codec_stream_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/codec_stream_arbiter.sv
// Two-source round-robin stream arbiter with per-grant burst limit and
// optional 16-bit-lane byte swap into a single registered output stage.
module codec_stream_arbiter #(
  parameter int BURST = 8
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        swap,
  input  logic [63:0] s0_axis_tdata,
  input  logic        s0_axis_tvalid,
  output logic        s0_axis_tready,
  input  logic [63:0] s1_axis_tdata,
  input  logic        s1_axis_tvalid,
  output logic        s1_axis_tready,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tid,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  localparam logic [7:0] BURST_LAST = 8'(BURST - 1);

  state_t      state_r;
  logic        last_r;
  logic        swap_r;
  logic [7:0]  cnt_r;
  logic [63:0] data_r;
  logic        valid_r;
  logic        tid_r;

  logic        out_free_s;
  logic        sel_valid_s;
  logic [63:0] sel_data_s;
  logic        accept_s;
  logic        s0_ready_s;
  logic        s1_ready_s;

  // Network order: swap the two bytes inside every 16-bit lane.
  function automatic logic [63:0] lane_swap(input logic [63:0] d);
    logic [63:0] r;
    r = 64'h0;
    for (int i = 0; i < 4; i++) begin
      r[16*i +: 16] = {d[16*i +: 8], d[16*i+8 +: 8]};
    end
    return r;
  endfunction

  // Source select and handshake for the granted requester.
  always_comb begin
    out_free_s  = !valid_r || m_axis_tready;
    s0_ready_s  = 1'b0;
    s1_ready_s  = 1'b0;
    sel_valid_s = 1'b0;
    sel_data_s  = s0_axis_tdata;
    case (state_r)
      GRANT0: begin
        s0_ready_s  = out_free_s;
        sel_valid_s = s0_axis_tvalid;
        sel_data_s  = s0_axis_tdata;
      end
      GRANT1: begin
        s1_ready_s  = out_free_s;
        sel_valid_s = s1_axis_tvalid;
        sel_data_s  = s1_axis_tdata;
      end
      default: begin
        s0_ready_s  = 1'b0;
        s1_ready_s  = 1'b0;
        sel_valid_s = 1'b0;
        sel_data_s  = s0_axis_tdata;
      end
    endcase
    accept_s = sel_valid_s && out_free_s;
  end

  // Arbitration FSM, burst counter and per-grant swap latch.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r <= IDLE;
      last_r  <= 1'b1;
      cnt_r   <= 8'd0;
      swap_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (s0_axis_tvalid && (!s1_axis_tvalid || last_r)) begin
            state_r <= GRANT0;
            last_r  <= 1'b0;
            cnt_r   <= 8'd0;
            swap_r  <= swap;
          end else if (s1_axis_tvalid) begin
            state_r <= GRANT1;
            last_r  <= 1'b1;
            cnt_r   <= 8'd0;
            swap_r  <= swap;
          end else begin
            state_r <= IDLE;
          end
        end
        GRANT0, GRANT1: begin
          if (accept_s) begin
            cnt_r <= cnt_r + 8'd1;
            if (cnt_r == BURST_LAST) begin
              state_r <= IDLE;
            end else begin
              state_r <= state_r;
            end
          end else if (out_free_s && !sel_valid_s) begin
            // A gap is only meaningful when the source was actually offered a slot.
            state_r <= IDLE;
          end else begin
            state_r <= state_r;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Single output register stage.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      data_r  <= 64'h0;
      valid_r <= 1'b0;
      tid_r   <= 1'b0;
    end else if (accept_s) begin
      data_r  <= swap_r ? lane_swap(sel_data_s) : sel_data_s;
      tid_r   <= (state_r == GRANT1);
      valid_r <= 1'b1;
    end else if (m_axis_tready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign s0_axis_tready = s0_ready_s;
  assign s1_axis_tready = s1_ready_s;
  assign m_axis_tdata   = data_r;
  assign m_axis_tvalid  = valid_r;
  assign m_axis_tid     = tid_r;
  assign busy           = (state_r != IDLE);

endmodule

// File: tb/tb_codec_stream_arbiter.sv
// Directed bench for codec_stream_arbiter: a BURST=8 instance for most steps
// and a BURST=4 instance for the round-robin sequence.
module tb_codec_stream_arbiter;

  logic        aclk;
  logic        aresetn;
  logic        swap;
  logic [63:0] s0_tdata, s1_tdata, m_tdata;
  logic        s0_tvalid, s0_tready, s1_tvalid, s1_tready;
  logic        m_tvalid, m_tready, m_tid, busy;

  logic        swap4;
  logic [63:0] a0_tdata, a1_tdata, m4_tdata;
  logic        v4, a0_tready, a1_tready, m4_tvalid, m4_tready, m4_tid, busy4;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit acc0, acc1;
  bit en0, en1;
  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic [63:0] obs_data[$];
  logic        obs_tid[$];
  logic [63:0] obs4_data[$];
  logic        obs4_tid[$];
  int          acc_cyc[$];

  codec_stream_arbiter #(.BURST(8)) u8 (
    .aclk(aclk), .aresetn(aresetn), .swap(swap),
    .s0_axis_tdata(s0_tdata), .s0_axis_tvalid(s0_tvalid), .s0_axis_tready(s0_tready),
    .s1_axis_tdata(s1_tdata), .s1_axis_tvalid(s1_tvalid), .s1_axis_tready(s1_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tid(m_tid), .busy(busy)
  );

  codec_stream_arbiter #(.BURST(4)) u4 (
    .aclk(aclk), .aresetn(aresetn), .swap(swap4),
    .s0_axis_tdata(a0_tdata), .s0_axis_tvalid(v4), .s0_axis_tready(a0_tready),
    .s1_axis_tdata(a1_tdata), .s1_axis_tvalid(v4), .s1_axis_tready(a1_tready),
    .m_axis_tdata(m4_tdata), .m_axis_tvalid(m4_tvalid), .m_axis_tready(m4_tready),
    .m_axis_tid(m4_tid), .busy(busy4)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic drive();
    s0_tvalid = en0 && (q0.size() != 0);
    s0_tdata  = (q0.size() != 0) ? q0[0] : 64'h0;
    s1_tvalid = en1 && (q1.size() != 0);
    s1_tdata  = (q1.size() != 0) ? q1[0] : 64'h0;
  endtask

  // Observe handshakes mid-cycle, then advance sources just after the edge.
  task automatic tick();
    @(negedge aclk);
    acc0 = s0_tvalid && s0_tready;
    acc1 = s1_tvalid && s1_tready;
    if (acc0) acc_cyc.push_back(cyc);
    if (m_tvalid && m_tready) begin
      obs_data.push_back(m_tdata);
      obs_tid.push_back(m_tid);
    end
    if (m4_tvalid && m4_tready) begin
      obs4_data.push_back(m4_tdata);
      obs4_tid.push_back(m4_tid);
    end
    @(posedge aclk);
    #1;
    cyc++;
    if (acc0) void'(q0.pop_front());
    if (acc1) void'(q1.pop_front());
    drive();
  endtask

  task automatic clear_obs();
    obs_data.delete();
    obs_tid.delete();
    acc_cyc.delete();
  endtask

  initial begin
    aresetn  = 1'b0;
    swap     = 1'b0;
    swap4    = 1'b0;
    m_tready = 1'b1;
    m4_tready = 1'b1;
    a0_tdata = 64'hA0;
    a1_tdata = 64'hB1;
    v4  = 1'b0;
    en0 = 1'b0;
    en1 = 1'b0;
    drive();
    #12;
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_m_tdata", m_tdata, 64'h0);
    chk("rst_m_tid", 64'(m_tid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_s0_tready", 64'(s0_tready), 64'd0);
    chk("rst_s1_tready", 64'(s1_tready), 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    // s0 alone, 10 words: 8-word burst, one idle cycle, then 2 words.
    for (int i = 0; i < 10; i++) q0.push_back(64'h1000 + 64'(i));
    en0 = 1'b1;
    drive();
    for (int k = 0; k < 40 && obs_data.size() < 10; k++) tick();
    chk("a_count", 64'(obs_data.size()), 64'd10);
    for (int i = 0; i < 10 && i < obs_data.size(); i++) begin
      chk("a_data", obs_data[i], 64'h1000 + 64'(i));
      chk("a_tid", 64'(obs_tid[i]), 64'd0);
    end
    if (acc_cyc.size() >= 10) begin
      chk("a_burst_span", 64'(acc_cyc[7] - acc_cyc[0]), 64'd7);
      chk("a_idle_gap", 64'(acc_cyc[8] - acc_cyc[7]), 64'd2);
      chk("a_second_grant", 64'(acc_cyc[9] - acc_cyc[8]), 64'd1);
    end
    for (int k = 0; k < 3; k++) tick();
    chk("a_busy_end", 64'(busy), 64'd0);
    chk("a_valid_end", 64'(m_tvalid), 64'd0);
    clear_obs();

    // Swap: one word, result visible one cycle after acceptance.
    swap = 1'b1;
    q0.push_back(64'h0123456789ABCDEF);
    drive();
    acc0 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (acc0) break;
    end
    chk("b_accepted", 64'(acc0), 64'd1);
    chk("b_valid", 64'(m_tvalid), 64'd1);
    chk("b_data", m_tdata, 64'h23016745AB89EFCD);
    chk("b_tid", 64'(m_tid), 64'd0);
    for (int k = 0; k < 3; k++) tick();
    clear_obs();
    swap = 1'b0;

    // Both sources on the BURST=4 instance: 0,0,0,0,1,1,1,1,0,0,0,0.
    v4 = 1'b1;
    for (int k = 0; k < 40 && obs4_tid.size() < 12; k++) tick();
    v4 = 1'b0;
    chk("c_count", 64'(obs4_tid.size() >= 12), 64'd1);
    for (int i = 0; i < 12 && i < obs4_tid.size(); i++) begin
      chk("c_tid", 64'(obs4_tid[i]), 64'(((i / 4) % 2) == 1));
      chk("c_data", obs4_data[i], (((i / 4) % 2) == 1) ? 64'hB1 : 64'hA0);
    end

    // Output stall with source tvalid dropped: word held, grant kept.
    for (int i = 0; i < 6; i++) q0.push_back(64'h2000 + 64'(i));
    drive();
    for (int k = 0; k < 20 && obs_data.size() < 2; k++) tick();
    m_tready = 1'b0;
    en0 = 1'b0;
    drive();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("d_hold_valid", 64'(m_tvalid), 64'd1);
      chk("d_hold_data", m_tdata, 64'h2002);
      chk("d_hold_busy", 64'(busy), 64'd1);
    end
    m_tready = 1'b1;
    en0 = 1'b1;
    drive();
    for (int k = 0; k < 30 && obs_data.size() < 6; k++) tick();
    for (int k = 0; k < 3; k++) tick();
    chk("d_count", 64'(obs_data.size()), 64'd6);
    for (int i = 0; i < 6 && i < obs_data.size(); i++) begin
      chk("d_data", obs_data[i], 64'h2000 + 64'(i));
    end
    clear_obs();

    // Swap toggled mid-grant: all six words keep the swap latched at entry.
    swap = 1'b1;
    for (int i = 0; i < 6; i++) q0.push_back({48'h112233445566, 8'h77, 8'(i)});
    drive();
    for (int k = 0; k < 20 && obs_data.size() < 2; k++) tick();
    swap = 1'b0;
    for (int k = 0; k < 30 && obs_data.size() < 6; k++) tick();
    chk("e_count", 64'(obs_data.size()), 64'd6);
    for (int i = 0; i < 6 && i < obs_data.size(); i++) begin
      chk("e_data", obs_data[i], {48'h221144336655, 8'(i), 8'h77});
    end
    for (int k = 0; k < 3; k++) tick();
    clear_obs();

    // Reset mid-burst: s1 holds the tie now, reset restores s0 priority.
    for (int i = 0; i < 4; i++) q0.push_back(64'h3000 + 64'(i));
    for (int i = 0; i < 4; i++) q1.push_back(64'h4000 + 64'(i));
    en1 = 1'b1;
    drive();
    for (int k = 0; k < 20 && obs_data.size() < 1; k++) tick();
    chk("f_pre_tid", (obs_tid.size() > 0) ? 64'(obs_tid[0]) : 64'd9, 64'd1);
    chk("f_pre_valid", 64'(m_tvalid), 64'd1);
    #3;
    aresetn = 1'b0;
    #1;
    chk("f_rst_valid", 64'(m_tvalid), 64'd0);
    chk("f_rst_data", m_tdata, 64'h0);
    chk("f_rst_busy", 64'(busy), 64'd0);
    chk("f_rst_s1_tready", 64'(s1_tready), 64'd0);
    q0.delete();
    q1.delete();
    for (int i = 0; i < 2; i++) q0.push_back(64'h5000 + 64'(i));
    for (int i = 0; i < 2; i++) q1.push_back(64'h6000 + 64'(i));
    drive();
    clear_obs();
    @(posedge aclk);
    #2;
    aresetn = 1'b1;
    for (int k = 0; k < 20 && obs_data.size() < 1; k++) tick();
    chk("f_post_count", 64'(obs_data.size() >= 1), 64'd1);
    if (obs_data.size() >= 1) begin
      chk("f_post_tid", 64'(obs_tid[0]), 64'd0);
      chk("f_post_data", obs_data[0], 64'h5000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
